// File: rtl/cross_bar_slave_mem.sv
// cross_bar_slave_mem
//   Memory responder for one slave port of cross_bar. Accepts a single request
//   at a time, pulses slave_ack ACK_LATENCY edges after the capture edge
//   (writes are committed on that same edge), and for reads pulses slave_resp
//   RESP_LATENCY edges after the ack with the word on slave_rdata.
//
//   Ports
//     clk          in   1   clock, rising edge
//     rst          in   1   asynchronous active-high reset
//     slave_req    in   1   request valid
//     slave_addr   in   32  [AW-1:0] word index, all other bits ignored
//     slave_cmd    in   1   0 = read, 1 = write
//     slave_wdata  in   32  write data
//     slave_ack    out  1   one-cycle accept pulse
//     slave_resp   out  1   one-cycle read-data-valid pulse
//     slave_rdata  out  32  read data, held until the next slave_resp
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for slave_req; captures addr/cmd/wdata on an edge
//   ACK_WAIT  | counting down to the ack edge; write commits / read samples
//   RESP_WAIT | read only: counting down to the resp edge
module cross_bar_slave_mem #(
    parameter int DEPTH        = 16,
    parameter int ACK_LATENCY  = 2,
    parameter int RESP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        slave_req,
    input  logic [31:0] slave_addr,
    input  logic        slave_cmd,
    input  logic [31:0] slave_wdata,
    output logic        slave_ack,
    output logic        slave_resp,
    output logic [31:0] slave_rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;
    localparam logic [CW-1:0] ACK_LOAD  = CW'(ACK_LATENCY - 1);
    localparam logic [CW-1:0] RESP_LOAD = CW'(RESP_LATENCY - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ACK_WAIT  = 2'd1;
    localparam logic [1:0] RESP_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          cmd_q, cmd_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   hold_q, hold_d;
    logic          ack_q, ack_d;
    logic          resp_q, resp_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mem_we;

    logic [31:0]   mem_q [DEPTH];

    // Address bits above the word index only select the slave upstream.
    logic          unused_addr;
    assign unused_addr = ^slave_addr[31:AW];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        ack_d   = 1'b0;
        resp_d  = 1'b0;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (slave_req) begin
                    idx_d   = slave_addr[AW-1:0];
                    cmd_d   = slave_cmd;
                    wdata_d = slave_wdata;
                    cnt_d   = ACK_LOAD;
                    state_d = ACK_WAIT;
                end
            end
            ACK_WAIT: begin
                if (cnt_q == '0) begin
                    ack_d = 1'b1;
                    if (cmd_q) begin
                        mem_we  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Sampled at ack so a read sees any earlier committed write;
                        // slave_rdata itself must not move until the resp edge.
                        hold_d  = mem_q[idx_q];
                        cnt_d   = RESP_LOAD;
                        state_d = RESP_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP_WAIT: begin
                if (cnt_q == '0) begin
                    resp_d  = 1'b1;
                    rdata_d = hold_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= '0;
            hold_q  <= '0;
            ack_q   <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            ack_q   <= ack_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
        end
    end

    // Array is deliberately not reset; a write only lands when the ack edge is
    // reached, so a reset before ack leaves the word untouched.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign slave_ack   = ack_q;
    assign slave_resp  = resp_q;
    assign slave_rdata = rdata_q;

endmodule
